// File: rtl/mod_pkg.sv
// Shared constants and types for the modular accumulator controller.
// The data width and operation encoding match the external modular adder.
package mod_pkg;

   localparam int W = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage : mod_pkg

// File: rtl/mod_accumulator.sv
// Running modulo-M accumulator wrapped around an external combinational adder.
// Operands arrive on a valid/ready stream and each result leaves on another.
module mod_accumulator #(
   parameter int M = 8,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_op,
   input  logic         in_load,
   input  logic [W-1:0] in_data,
   output logic         add_s,
   output logic [W-1:0] add_x,
   output logic [W-1:0] add_y,
   input  logic [W-1:0] add_z,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         err,
   output logic [7:0]   op_count
);

   import mod_pkg::*;

   // One extra bit so that M = 16 is still representable for the range check.
   localparam logic [W:0] M_LIM = (W+1)'(M);

   state_t       state_r;
   state_t       state_s;
   logic [W-1:0] acc_r;
   logic [W-1:0] acc_s;
   logic [W-1:0] opnd_r;
   logic [W-1:0] opnd_s;
   logic         op_r;
   logic         op_s;
   logic [7:0]   cnt_r;
   logic [7:0]   cnt_s;
   logic         err_r;
   logic         err_s;
   logic         in_ready_r;
   logic         out_valid_r;
   logic         accept_s;
   logic         range_ok_s;

   assign accept_s   = in_valid && in_ready_r;
   assign range_ok_s = ({1'b0, in_data} < M_LIM);

   // Next-state, accumulator, operand and counter update logic.
   always_comb begin
      state_s = state_r;
      acc_s   = acc_r;
      opnd_s  = opnd_r;
      op_s    = op_r;
      cnt_s   = cnt_r;
      err_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (!range_ok_s) begin
                  err_s   = 1'b1;
                  state_s = IDLE;
               end else if (in_load) begin
                  acc_s   = in_data;
                  state_s = HOLD;
               end else begin
                  opnd_s  = in_data;
                  op_s    = in_op;
                  state_s = CALC;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            acc_s   = add_z;
            state_s = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               cnt_s   = cnt_r + 8'd1;
               state_s = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and datapath registers; handshake flags are registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         acc_r       <= '0;
         opnd_r      <= '0;
         op_r        <= OP_ADD;
         cnt_r       <= 8'd0;
         err_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         acc_r       <= acc_s;
         opnd_r      <= opnd_s;
         op_r        <= op_s;
         cnt_r       <= cnt_s;
         err_r       <= err_s;
         in_ready_r  <= (state_s == IDLE);
         out_valid_r <= (state_s == HOLD);
      end
   end

   // Operand register only changes on an add/sub accept, so add_s/add_y hold outside CALC.
   assign add_s     = op_r;
   assign add_x     = acc_r;
   assign add_y     = opnd_r;
   assign out_data  = acc_r;
   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign err       = err_r;
   assign op_count  = cnt_r;

endmodule : mod_accumulator

// File: tb/tb_mod_accumulator.sv
// Self-checking bench for mod_accumulator with a behavioural (x +/- y) mod M adder
// and a plain-arithmetic model of the accumulator and operation counter.
module tb_mod_accumulator;

   localparam int M = 8;
   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         in_op;
   logic         in_load;
   logic [W-1:0] in_data;
   logic         add_s;
   logic [W-1:0] add_x;
   logic [W-1:0] add_y;
   logic [W-1:0] add_z;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         err;
   logic [7:0]   op_count;

   int         checks   = 0;
   int         failures = 0;
   int         acc_m    = 0;
   logic [7:0] cnt_m    = 8'd0;

   mod_accumulator #(.M(M), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_load(in_load), .in_data(in_data),
      .add_s(add_s), .add_x(add_x), .add_y(add_y), .add_z(add_z),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .err(err), .op_count(op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the external modular adder.
   always_comb begin
      if (add_s) add_z = 4'((int'(add_x) - int'(add_y) + 4 * M) % M);
      else       add_z = 4'((int'(add_x) + int'(add_y)) % M);
   end

   function automatic int mod_res(input int a, input int b, input logic sub);
      int r;
      r = sub ? (a - b) : (a + b);
      return ((r % M) + M) % M;
   endfunction

   // One complete transaction from an IDLE controller, ending on a negedge back in IDLE.
   task automatic run_op(input logic ld, input logic op, input int d, input int stall);
      int exp_v;
      in_valid = 1'b1; in_load = ld; in_op = op; in_data = 4'(d); out_ready = (stall == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      if (d >= M) begin
         checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_pulse d=%0d got=%b exp=1", d, err); end
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL err_no_out got=%b exp=0", out_valid); end
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL err_ready got=%b exp=1", in_ready); end
         @(negedge clk);
         checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", err); end
         checks++; if (out_data !== 4'(acc_m)) begin failures++; $display("FAIL err_acc got=%0d exp=%0d", out_data, acc_m); end
         checks++; if (op_count !== cnt_m) begin failures++; $display("FAIL err_count got=%0d exp=%0d", op_count, cnt_m); end
         return;
      end
      if (!ld) begin
         exp_v = mod_res(acc_m, d, op);
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL calc_flags ready=%b valid=%b exp=0/0", in_ready, out_valid); end
         checks++; if (add_s !== op) begin failures++; $display("FAIL calc_add_s got=%b exp=%b", add_s, op); end
         checks++; if (add_x !== 4'(acc_m) || add_y !== 4'(d)) begin failures++; $display("FAIL calc_xy got=%0d/%0d exp=%0d/%0d", add_x, add_y, acc_m, d); end
         @(negedge clk);
      end else begin
         exp_v = d;
      end
      acc_m = exp_v;
      checks++; if (out_valid !== 1'b1 || out_data !== 4'(exp_v)) begin failures++; $display("FAIL result valid=%b data=%0d exp=1/%0d", out_valid, out_data, exp_v); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b exp=0", in_ready); end
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || out_data !== 4'(exp_v)) begin failures++; $display("FAIL stall_hold valid=%b data=%0d exp=1/%0d", out_valid, out_data, exp_v); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      cnt_m = cnt_m + 8'd1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL done_flags valid=%b ready=%b exp=0/1", out_valid, in_ready); end
      checks++; if (op_count !== cnt_m) begin failures++; $display("FAIL op_count got=%0d exp=%0d", op_count, cnt_m); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_load = 1'b0; in_data = 4'd0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_flags ready=%b valid=%b err=%b", in_ready, out_valid, err); end
      checks++; if (out_data !== 4'd0 || op_count !== 8'd0) begin failures++; $display("FAIL reset_data data=%0d count=%0d exp=0/0", out_data, op_count); end
      checks++; if (add_s !== 1'b0 || add_x !== 4'd0 || add_y !== 4'd0) begin failures++; $display("FAIL reset_adder s=%b x=%0d y=%0d exp=0", add_s, add_x, add_y); end
      acc_m = 0; cnt_m = 8'd0;
   endtask

   task automatic test_add();
      run_op(1'b0, 1'b0, 5, 0);
      run_op(1'b0, 1'b0, 6, 0);
      checks++; if (op_count !== 8'd2 || out_data !== 4'd3) begin failures++; $display("FAIL add_seq count=%0d data=%0d exp=2/3", op_count, out_data); end
   endtask

   task automatic test_sub();
      run_op(1'b0, 1'b1, 7, 0);
      run_op(1'b0, 1'b1, 4, 0);
      checks++; if (out_data !== 4'd0) begin failures++; $display("FAIL sub_seq got=%0d exp=0", out_data); end
   endtask

   task automatic test_load();
      run_op(1'b1, 1'b1, 6, 0);
      run_op(1'b0, 1'b0, 2, 0);
      checks++; if (out_data !== 4'd0) begin failures++; $display("FAIL load_add got=%0d exp=0", out_data); end
   endtask

   task automatic test_range();
      run_op(1'b0, 1'b0, 9, 0);
      run_op(1'b1, 1'b0, 8, 0);
      run_op(1'b0, 1'b0, 7, 0);
   endtask

   task automatic test_back_to_back();
      run_op(1'b1, 1'b0, 0, 0);
      in_valid = 1'b1; in_load = 1'b0; in_op = 1'b0; in_data = 4'd5; out_ready = 1'b0;
      @(posedge clk); #1;
      in_data = 4'd2;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b1 || out_data !== 4'd5 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold valid=%b data=%0d ready=%b exp=1/5/0", out_valid, out_data, in_ready); end
         checks++; if (op_count !== cnt_m) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", op_count, cnt_m); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      cnt_m = cnt_m + 8'd1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_count !== cnt_m) begin failures++; $display("FAIL bp_release ready=%b valid=%b count=%0d", in_ready, out_valid, op_count); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (add_y !== 4'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_next_calc y=%0d ready=%b exp=2/0", add_y, in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 4'd7) begin failures++; $display("FAIL bp_next_result valid=%b data=%0d exp=1/7", out_valid, out_data); end
      @(negedge clk);
      cnt_m = cnt_m + 8'd1; acc_m = 7;
      checks++; if (op_count !== cnt_m) begin failures++; $display("FAIL bp_next_count got=%0d exp=%0d", op_count, cnt_m); end
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; in_load = 1'b0; in_op = 1'b1; in_data = 4'd3; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL midrst_flags ready=%b valid=%b err=%b", in_ready, out_valid, err); end
      checks++; if (out_data !== 4'd0 || op_count !== 8'd0 || add_s !== 1'b0 || add_y !== 4'd0) begin failures++; $display("FAIL midrst_regs data=%0d count=%0d s=%b y=%0d", out_data, op_count, add_s, add_y); end
      @(negedge clk);
      rst_n = 1'b1;
      acc_m = 0; cnt_m = 8'd0;
      @(negedge clk);
      run_op(1'b0, 1'b0, 1, 0);
      checks++; if (out_data !== 4'd1 || op_count !== 8'd1) begin failures++; $display("FAIL midrst_after data=%0d count=%0d exp=1/1", out_data, op_count); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 80; n++) begin
         run_op(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_load();
      test_range();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mod_accumulator
